// File: rtl/frame_writer.sv
// Packs a raster stream of 8-bit palette indices into 128-bit words and writes
// them, one SDRAM request per word, into whichever frame buffer is not on screen.
module frame_writer #(
  parameter logic [21:0] Address1 = 22'h100000,
  parameter logic [21:0] Address2 = 22'h200000,
  parameter int          H_WORDS  = 40,
  parameter int          V_LINES  = 480
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         frame_start,
  input  logic         frame_flip,
  input  logic         pix_valid,
  input  logic [7:0]   pix_data,
  output logic         pix_ready,
  input  logic         sdram_Wait,
  input  logic         sdram_ac,
  output logic         sdram_wr,
  output logic [21:0]  sdram_addr,
  output logic [127:0] sdram_wdata,
  output logic         busy,
  output logic         done,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [9:0] X_LAST = 10'((H_WORDS - 1) * 16);
  localparam logic [9:0] Y_LAST = 10'(V_LINES - 1);

  state_t      state, state_next;
  logic [21:0] base;
  logic [9:0]  write_x;
  logic [9:0]  write_y;
  logic [3:0]  sub;
  logic [21:0] offset;
  logic        pix_take, word_ack, line_end, frame_end, start_take;

  // Handshakes: a pixel moves on a rising edge with pix_valid && pix_ready;
  // a word is committed on a rising edge with sdram_ac while in WRITE, and
  // sdram_wr/addr/wdata stay put until then (sdram_wr masked by sdram_Wait).
  assign pix_take   = (state == FILL) && pix_valid;
  assign word_ack   = (state == WRITE) && sdram_ac;
  assign start_take = ((state == IDLE) || (state == DONE)) && frame_start;
  assign line_end   = (write_x == X_LAST);
  assign frame_end  = line_end && (write_y == Y_LAST);

  assign offset     = 22'(32'(write_y) * 32'(H_WORDS)) + 22'(write_x[9:4]);
  assign sdram_addr = base + offset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    pix_ready  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    sdram_wr   = 1'b0;
    state_dbg  = state;
    case (state)
      IDLE: begin
        if (frame_start) state_next = FILL;
      end
      FILL: begin
        pix_ready = 1'b1;
        busy      = 1'b1;
        if (pix_valid && (sub == 4'd15)) state_next = WRITE;
      end
      WRITE: begin
        busy     = 1'b1;
        sdram_wr = ~sdram_Wait;
        if (sdram_ac) state_next = frame_end ? DONE : FILL;
      end
      DONE: begin
        done = 1'b1;
        if (frame_start) state_next = FILL;
      end
      default: state_next = IDLE;
    endcase
  end

  // Position counters track the word being filled/written; the address is
  // derived from them so it cannot drift while a request is pending.
  always_ff @(posedge clock) begin
    if (reset) begin
      base        <= Address1;
      write_x     <= '0;
      write_y     <= '0;
      sub         <= '0;
      sdram_wdata <= '0;
    end else if (start_take) begin
      base    <= frame_flip ? Address2 : Address1;
      write_x <= '0;
      write_y <= '0;
      sub     <= '0;
    end else if (pix_take) begin
      sdram_wdata[{sub, 3'b000} +: 8] <= pix_data;
      sub <= sub + 4'd1;
    end else if (word_ack) begin
      if (line_end) begin
        write_x <= '0;
        write_y <= write_y + 10'd1;
      end else begin
        write_x <= write_x + 10'd16;
      end
    end
  end

endmodule

// File: tb/tb_frame_writer.sv
// Randomized bench for frame_writer: a frame-level model predicts each SDRAM
// word as (buffer base + linear word index, 16 packed pixels).
module tb_frame_writer;

  localparam int          H_W     = 40;
  localparam int          V_L     = 4;
  localparam int          FW      = H_W * V_L;
  localparam logic [21:0] ADDR_A  = 22'h100000;
  localparam logic [21:0] ADDR_B  = 22'h200000;
  localparam logic [1:0]  ST_IDLE = 2'd0;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         frame_start = 1'b0;
  logic         frame_flip = 1'b0;
  logic         pix_valid = 1'b0;
  logic [7:0]   pix_data = 8'h00;
  logic         pix_ready;
  logic         sdram_Wait = 1'b0;
  logic         sdram_ac = 1'b0;
  logic         sdram_wr;
  logic [21:0]  sdram_addr;
  logic [127:0] sdram_wdata;
  logic         busy;
  logic         done;
  logic [1:0]   state_dbg;

  frame_writer #(.Address1(ADDR_A), .Address2(ADDR_B), .H_WORDS(H_W), .V_LINES(V_L)) dut (
    .clock(clock), .reset(reset), .frame_start(frame_start), .frame_flip(frame_flip),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .sdram_Wait(sdram_Wait), .sdram_ac(sdram_ac), .sdram_wr(sdram_wr),
    .sdram_addr(sdram_addr), .sdram_wdata(sdram_wdata), .busy(busy), .done(done),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [149:0] exp_q[$];
  logic [21:0]  model_base;
  int           word_idx;
  int           checks = 0;
  int           errors = 0;
  int           acks;
  logic [21:0]  last_addr;
  bit           stuck = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_pixel(input logic [7:0] d);
    int t;
    if (stuck) return;
    if ($urandom_range(0, 3) == 0) begin
      sdram_ac = 1'($urandom_range(0, 1));
      @(negedge clock);
    end
    pix_valid = 1'b1;
    pix_data  = d;
    sdram_ac  = ($urandom_range(0, 4) == 0);
    t = 0;
    while (!pix_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (t == 50) begin
      check("pix_ready_timeout", 1'b0, 1'b1);
      stuck = 1;
    end
    @(negedge clock);
    pix_valid = 1'b0;
    sdram_ac  = 1'b0;
  endtask

  task automatic send_word(input logic [127:0] d, input bit mid_start, input bit stall);
    exp_q.push_back({22'(model_base + 22'(word_idx)), d});
    word_idx++;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) sdram_Wait = stall;
      if (mid_start && i == 5) frame_start = 1'b1;
      push_pixel(d[8*i +: 8]);
      frame_start = 1'b0;
    end
  endtask

  task automatic serve_word(input int stall, input int ack_dly);
    logic [149:0] exp;
    exp = exp_q.pop_front();
    check("in_write", {busy, pix_ready}, 2'b10);
    for (int i = 0; i < stall; i++) begin
      check("wr_stalled", sdram_wr, 1'b0);
      check("addr_stalled", sdram_addr, exp[149:128]);
      check("wdata_stalled", sdram_wdata, exp[127:0]);
      @(negedge clock);
    end
    sdram_Wait = 1'b0;
    #1;
    for (int i = 0; i <= ack_dly; i++) begin
      check("wr_held", sdram_wr, 1'b1);
      if (i < ack_dly) @(negedge clock);
    end
    check("addr", sdram_addr, exp[149:128]);
    check("wdata", sdram_wdata, exp[127:0]);
    last_addr = sdram_addr;
    sdram_ac = 1'b1;
    acks++;
    @(negedge clock);
    sdram_ac = 1'b0;
  endtask

  task automatic run_frame(input logic flip, input int nwords, input bit fixed_first,
                           input int mid_word, input int stall_word);
    logic [127:0] d;
    frame_flip  = flip;
    frame_start = 1'b1;
    @(negedge clock);
    frame_start = 1'b0;
    frame_flip  = 1'($urandom_range(0, 1));
    model_base  = flip ? ADDR_B : ADDR_A;
    word_idx    = 0;
    acks        = 0;
    for (int w = 0; w < nwords; w++) begin
      if (fixed_first && w == 0) d = 128'h0F0E0D0C0B0A09080706050403020100;
      else d = {$urandom, $urandom, $urandom, $urandom};
      send_word(d, w == mid_word, w == stall_word);
      serve_word((w == stall_word) ? 10 : 0,
                 (fixed_first && w == 0) ? 2 : $urandom_range(0, 3));
      if (w == 0)  check("word0_addr", last_addr, flip ? 22'h200000 : 22'h100000);
      if (w == 40) check("word40_addr", last_addr, flip ? 22'h200028 : 22'h100028);
      if (stuck) break;
    end
    if (nwords == FW) begin
      check("ack_count", acks, FW);
      check("last_addr", last_addr, 22'(model_base + 22'(FW - 1)));
      check("done_high", done, 1'b1);
      check("done_not_busy", busy, 1'b0);
      pix_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(negedge clock);
        check("done_pix_ready", pix_ready, 1'b0);
        check("done_no_wr", sdram_wr, 1'b0);
      end
      pix_valid = 1'b0;
      check("done_held", done, 1'b1);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("rst_state", state_dbg, ST_IDLE);
    check("rst_wr", sdram_wr, 1'b0);
    check("rst_pix_ready", pix_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_wdata", sdram_wdata, 128'h0);
    check("rst_addr", sdram_addr, ADDR_A);

    // Full frame into buffer A; known first word, frame_start noise mid-fill
    run_frame(1'b0, FW, 1'b1, 7, -1);

    // 41 words into buffer B with one long SDRAM stall
    run_frame(1'b1, 41, 1'b0, -1, 5);

    // Reset while a request is pending
    send_word({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
    check("wr_before_reset", sdram_wr, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mid_reset_state", state_dbg, ST_IDLE);
    check("mid_reset_wr", sdram_wr, 1'b0);
    check("mid_reset_busy", busy, 1'b0);
    check("mid_reset_pix_ready", pix_ready, 1'b0);
    void'(exp_q.pop_front());

    // Restart after reset: full frame into buffer A
    run_frame(1'b0, FW, 1'b0, 20, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
